if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of instruction decode. It feeds the IF/ID register whose instruction opcode field drives the main decode controller.
- Holds the PC and issues instruction-memory requests.
- Applies redirects from EX (taken branch, JAL, JALR) and stalls from the hazard unit.
- Stops fetching permanently once decode reports a HALT instruction.

---
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, and loads the IF/ID register.
// Applies EX redirects, hazard stalls and a permanent stop after a decoded HALT.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Stall,
   input  logic             Redirect,
   input  logic [31:0]      RedirectPC,
   input  logic             HaltDec,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic [31:0]      IF_PC,
   output logic [31:0]      IF_Inst,
   output logic             IF_Valid,
   output logic             Halted,
   output logic [CNT_W-1:0] FetchCount
);

   typedef enum logic {FETCH, HALTED} state_t;

   state_t           state, state_n;
   logic [31:0]      pc, pc_n;
   logic [31:0]      if_pc_n, if_inst_n;
   logic             if_valid_n, halted_n;
   logic [CNT_W-1:0] count_n;
   logic             halt_hit;

   assign halt_hit  = HaltDec & IF_Valid;
   assign imem_addr = pc;
   assign imem_req  = (state == FETCH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         IF_PC      <= 32'h0;
         IF_Inst    <= NOP_INST;
         IF_Valid   <= 1'b0;
         Halted     <= 1'b0;
         FetchCount <= '0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         IF_PC      <= if_pc_n;
         IF_Inst    <= if_inst_n;
         IF_Valid   <= if_valid_n;
         Halted     <= halted_n;
         FetchCount <= count_n;
      end
   end

   // A redirect outranks a HALT in ID because that HALT is on the squashed wrong path.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      if_pc_n    = IF_PC;
      if_inst_n  = IF_Inst;
      if_valid_n = IF_Valid;
      halted_n   = Halted;
      count_n    = FetchCount;
      if (state == FETCH) begin
         if (Redirect) begin
            pc_n       = {RedirectPC[31:2], 2'b00};
            if_valid_n = 1'b0;
            if_inst_n  = NOP_INST;
         end else if (halt_hit) begin
            state_n    = HALTED;
            halted_n   = 1'b1;
            if_valid_n = 1'b0;
            if_inst_n  = NOP_INST;
         end else if (Stall) begin
            pc_n = pc;
         end else if (!imem_ready) begin
            if_valid_n = 1'b0;
            if_inst_n  = NOP_INST;
         end else begin
            if_pc_n    = pc;
            if_inst_n  = imem_rdata;
            if_valid_n = 1'b1;
            pc_n       = pc + 32'd4;
            if (FetchCount != {CNT_W{1'b1}})
               count_n = FetchCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; a second instance with a 3-bit counter covers saturation.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall, Redirect, HaltDec, imem_ready;
   logic [31:0] RedirectPC;
   logic        imem_req, IF_Valid, Halted;
   logic [31:0] imem_addr, imem_rdata, IF_PC, IF_Inst;
   logic [15:0] FetchCount;
   logic        imem_req_s, IF_Valid_s, Halted_s;
   logic [31:0] imem_addr_s, IF_PC_s, IF_Inst_s;
   logic [2:0]  FetchCount_s;
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] NOP = 32'h00000013;

   always #5 clk = ~clk;

   // Memory returns the word address as the instruction word.
   assign imem_rdata = imem_addr;

   if_stage dut (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .HaltDec(HaltDec), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .IF_PC(IF_PC), .IF_Inst(IF_Inst), .IF_Valid(IF_Valid), .Halted(Halted),
      .FetchCount(FetchCount)
   );

   if_stage #(.CNT_W(3)) dutSmall (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .HaltDec(HaltDec), .imem_req(imem_req_s),
      .imem_addr(imem_addr_s), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .IF_PC(IF_PC_s), .IF_Inst(IF_Inst_s), .IF_Valid(IF_Valid_s), .Halted(Halted_s),
      .FetchCount(FetchCount_s)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs, clock them in, and settle 1 time unit past the edge.
   task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic hd, input logic rdy);
      Stall      = st;
      Redirect   = rd;
      RedirectPC = rpc;
      HaltDec    = hd;
      imem_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
      HaltDec = 1'b0; imem_ready = 1'b1;
      #1;
      checkOutput("rst_addr",  imem_addr, 32'h0);
      checkOutput("rst_req",   {31'h0, imem_req}, 32'h1);
      checkOutput("rst_valid", {31'h0, IF_Valid}, 32'h0);
      checkOutput("rst_inst",  IF_Inst, NOP);
      checkOutput("rst_count", {16'h0, FetchCount}, 32'h0);
      checkOutput("rst_halt",  {31'h0, Halted}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Straight-line fetch: IF_PC lags imem_addr by one cycle
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("f1_pc",    IF_PC, 32'h0);
      checkOutput("f1_valid", {31'h0, IF_Valid}, 32'h1);
      checkOutput("f1_addr",  imem_addr, 32'h4);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("f2_pc",    IF_PC, 32'h4);
      checkOutput("f2_addr",  imem_addr, 32'h8);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("f3_pc",    IF_PC, 32'h8);
      checkOutput("f3_inst",  IF_Inst, 32'h8);
      checkOutput("f3_addr",  imem_addr, 32'hC);

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 0, 0, 1);
         checkOutput("stall_pc",    IF_PC, 32'h8);
         checkOutput("stall_inst",  IF_Inst, 32'h8);
         checkOutput("stall_addr",  imem_addr, 32'hC);
         checkOutput("stall_count", {16'h0, FetchCount}, 32'd3);
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("unstall_pc",    IF_PC, 32'hC);
      checkOutput("unstall_count", {16'h0, FetchCount}, 32'd4);

      // Redirect wins over a simultaneous stall and aligns the target
      applyStimulus(1, 1, 32'h103, 0, 1);
      checkOutput("redir_addr",  imem_addr, 32'h100);
      checkOutput("redir_valid", {31'h0, IF_Valid}, 32'h0);
      checkOutput("redir_inst",  IF_Inst, NOP);
      checkOutput("redir_count", {16'h0, FetchCount}, 32'd4);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("bub_valid", {31'h0, IF_Valid}, 32'h0);
         checkOutput("bub_inst",  IF_Inst, NOP);
         checkOutput("bub_addr",  imem_addr, 32'h100);
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("afterbub_pc",    IF_PC, 32'h100);
      checkOutput("afterbub_count", {16'h0, FetchCount}, 32'd5);

      // HALT in ID is squashed by a same-cycle redirect
      applyStimulus(0, 1, 32'h200, 1, 1);
      checkOutput("hr_halt",  {31'h0, Halted}, 32'h0);
      checkOutput("hr_addr",  imem_addr, 32'h200);
      checkOutput("hr_valid", {31'h0, IF_Valid}, 32'h0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("hr_next_pc", IF_PC, 32'h200);

      applyStimulus(0, 1, 32'hFFFFFFFC, 0, 1);
      checkOutput("wrap_pre", imem_addr, 32'hFFFFFFFC);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wrap_addr",   imem_addr, 32'h0);
      checkOutput("wrap_ifpc",   IF_PC, 32'hFFFFFFFC);
      checkOutput("small_cnt7",  {29'h0, FetchCount_s}, 32'd7);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("count8",      {16'h0, FetchCount}, 32'd8);
      checkOutput("small_sat",   {29'h0, FetchCount_s}, 32'd7);

      // Real HALT: fetch stops and later redirects are ignored
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("halt_flag",  {31'h0, Halted}, 32'h1);
      checkOutput("halt_req",   {31'h0, imem_req}, 32'h0);
      checkOutput("halt_valid", {31'h0, IF_Valid}, 32'h0);
      checkOutput("halt_addr",  imem_addr, 32'h4);
      applyStimulus(1, 1, 32'h40, 0, 1);
      checkOutput("halted_addr",  imem_addr, 32'h4);
      checkOutput("halted_flag",  {31'h0, Halted}, 32'h1);
      checkOutput("halted_count", {16'h0, FetchCount}, 32'd8);

      reset = 1'b1; #1; reset = 1'b0;
      checkOutput("unhalt_flag", {31'h0, Halted}, 32'h0);
      checkOutput("unhalt_req",  {31'h0, imem_req}, 32'h1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("restart_pc",    IF_PC, 32'h4);
      checkOutput("restart_count", {16'h0, FetchCount}, 32'd2);

      // Asynchronous reset pulse between edges while stalled
      Stall = 1'b1;
      #2 reset = 1'b1;
      #1;
      checkOutput("arst_addr",  imem_addr, 32'h0);
      checkOutput("arst_ifpc",  IF_PC, 32'h0);
      checkOutput("arst_inst",  IF_Inst, NOP);
      checkOutput("arst_count", {16'h0, FetchCount}, 32'h0);
      #1 reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("arst_next_addr", imem_addr, 32'h4);
      checkOutput("arst_next_cnt",  {16'h0, FetchCount}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
